// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C byte transmitter
// Contents: FSM state enum, SCL quarter-phase enum, ACK/NACK bus levels.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD,
    BIT,
    ACK,
    STOP
  } state_t;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } qtr_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_qtr_timer.sv
// rtl/i2c_qtr_timer.sv - quarter-SCL-period timer with clear and stretch hold
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : force count to 0 (used while the FSM is not timing a quarter)
//   hold     : keep count at 0 (slave stretching SCL low)
//   qtick    : terminal count reached this cycle, quarter ends at this edge
module i2c_qtr_timer #(
  parameter int QTR_CNT = 63
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic hold,
  output logic qtick
);

  localparam int W = $clog2(QTR_CNT);
  localparam logic [W-1:0] LAST = W'(QTR_CNT - 1);

  logic [W-1:0] cnt;

  assign qtick = (cnt == LAST) && !hold && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || hold) begin
      cnt <= '0;
    end else if (qtick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master_byte_tx.sv
// rtl/i2c_master_byte_tx.sv - I2C master transmitter: START, MSB-first bytes, ACK sample, STOP
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start_req           : pulse to begin a transaction (ignored while busy or during done)
//   tx_byte, last_byte  : byte to send and STOP-after-this flag, qualified by byte_valid
//   byte_valid/ready    : byte handshake, ready is high while waiting in LOAD
//   scl_in, sda_in      : synchronized pad readback (stretch detect, ACK sample)
//   scl_out, sda_out    : 1 = release line, 0 = drive low
//   busy, done          : transaction in progress, one-cycle completion pulse
//   ack_error           : with done, 1 = transaction ended on a NACK
module i2c_master_byte_tx
  import i2c_pkg::*;
#(
  parameter int QTR_CNT = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_req,
  input  logic [7:0] tx_byte,
  input  logic       byte_valid,
  input  logic       last_byte,
  output logic       byte_ready,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_out,
  output logic       sda_out,
  output logic       busy,
  output logic       done,
  output logic       ack_error
);

  state_t     state;
  qtr_t       qtr;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       last_flag;
  logic       nack;
  logic       qtick;
  logic       tmr_clear;
  logic       tmr_hold;

  // Timer only runs in states that time quarters; IDLE and LOAD keep it at 0
  // so the first quarter after leaving them is full length.
  assign tmr_clear = (state == IDLE) || (state == LOAD);

  // SCL was released this quarter but the bus is still low: a slave is
  // stretching, so the high phase does not start counting yet.
  assign tmr_hold = !scl_in &&
                    ((((state == BIT) || (state == ACK)) && (qtr == Q2)) ||
                     ((state == STOP) && (qtr == Q1)));

  i2c_qtr_timer #(
    .QTR_CNT(QTR_CNT)
  ) u_qtr_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(tmr_clear),
    .hold (tmr_hold),
    .qtick(qtick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      qtr        <= Q0;
      scl_out    <= 1'b1;
      sda_out    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      ack_error  <= 1'b0;
      byte_ready <= 1'b0;
      shift      <= 8'h00;
      bit_cnt    <= 3'd0;
      last_flag  <= 1'b0;
      nack       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          scl_out <= 1'b1;
          sda_out <= 1'b1;
          // A request landing on the done cycle belongs to the finished
          // transaction's handshake window and is dropped.
          if (start_req && !done) begin
            state   <= START;
            qtr     <= Q0;
            busy    <= 1'b1;
            sda_out <= 1'b0;
            nack    <= 1'b0;
          end
        end

        START: begin
          if (qtick) begin
            if (qtr == Q0) begin
              qtr <= Q1;
            end else begin
              scl_out    <= 1'b0;
              state      <= LOAD;
              byte_ready <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (byte_valid && byte_ready) begin
            shift      <= tx_byte;
            last_flag  <= last_byte;
            bit_cnt    <= 3'd7;
            byte_ready <= 1'b0;
            sda_out    <= tx_byte[7];
            state      <= BIT;
            qtr        <= Q0;
          end
        end

        BIT, ACK: begin
          if (qtick) begin
            case (qtr)
              Q0: qtr <= Q1;
              Q1: begin
                qtr     <= Q2;
                scl_out <= 1'b1;
              end
              Q2: begin
                qtr <= Q3;
                if (state == ACK) nack <= sda_in;
              end
              Q3: begin
                qtr     <= Q0;
                scl_out <= 1'b0;
                if (state == BIT) begin
                  if (bit_cnt != 3'd0) begin
                    bit_cnt <= bit_cnt - 3'd1;
                    sda_out <= shift[bit_cnt - 3'd1];
                  end else begin
                    state   <= ACK;
                    sda_out <= 1'b1;
                  end
                end else if ((nack == I2C_ACK) && !last_flag) begin
                  state      <= LOAD;
                  byte_ready <= 1'b1;
                  sda_out    <= 1'b1;
                end else begin
                  state   <= STOP;
                  sda_out <= 1'b0;
                end
              end
            endcase
          end
        end

        STOP: begin
          if (qtick) begin
            case (qtr)
              Q0: begin
                qtr     <= Q1;
                scl_out <= 1'b1;
              end
              Q1: begin
                qtr     <= Q2;
                sda_out <= 1'b1;
              end
              Q2: qtr <= Q3;
              Q3: begin
                state     <= IDLE;
                qtr       <= Q0;
                done      <= 1'b1;
                ack_error <= nack;
                busy      <= 1'b0;
              end
            endcase
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_byte_tx.sv
// tb/tb_i2c_master_byte_tx.sv - scoreboard bench for i2c_master_byte_tx with a bus-level slave model
module tb_i2c_master_byte_tx;

  localparam int QTR_CNT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_req;
  logic [7:0] tx_byte;
  logic       byte_valid;
  logic       last_byte;
  logic       byte_ready;
  logic       scl_in;
  logic       sda_in;
  logic       scl_out;
  logic       sda_out;
  logic       busy;
  logic       done;
  logic       ack_error;
  logic       stretch = 1'b0;
  logic       ack_drive = 1'b0;

  // Wired-AND bus: slave may stretch SCL and pull SDA for ACK.
  assign scl_in = scl_out & ~stretch;
  assign sda_in = sda_out & ~ack_drive;

  always #5 clk = ~clk;

  i2c_master_byte_tx #(
    .QTR_CNT(QTR_CNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_req (start_req),
    .tx_byte   (tx_byte),
    .byte_valid(byte_valid),
    .last_byte (last_byte),
    .byte_ready(byte_ready),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_out   (scl_out),
    .sda_out   (sda_out),
    .busy      (busy),
    .done      (done),
    .ack_error (ack_error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  // Scoreboard queues
  logic [7:0] exp_byte_q[$];
  logic       exp_nack_q[$];
  logic       exp_err_q[$];

  // Bus monitor state
  int         start_cnt = 0, stop_cnt = 0, rise_cnt = 0, acc_cnt = 0, done_cnt = 0;
  int         max_hi = 0, out_len = 0, bitn = 0;
  logic       out_active = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_sclo = 1'b1;
  logic [7:0] cap = 8'h00;
  logic       e_err;

  always @(posedge clk) begin
    if (!rst && byte_valid && byte_ready) acc_cnt++;
  end

  always @(negedge clk) begin
    if (rst) begin
      bitn       = 0;
      ack_drive  = 1'b0;
      out_active = 1'b0;
      prev_scl   = 1'b1;
      prev_sda   = 1'b1;
      prev_sclo  = 1'b1;
    end else begin
      if (done) begin
        done_cnt++;
        if (exp_err_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e_err = exp_err_q.pop_front();
          check("ack_error", ack_error, e_err);
          check("busy_at_done", busy, 0);
        end
      end
      if (prev_scl && scl_in && prev_sda && !sda_in) begin
        start_cnt++;
        bitn       = 0;
        out_active = 1'b0;
      end else if (prev_scl && scl_in && !prev_sda && sda_in) begin
        stop_cnt++;
        bitn = 0;
      end
      if (!prev_scl && scl_in) begin
        rise_cnt++;
        if (bitn < 8) begin
          cap = {cap[6:0], sda_in};
          bitn++;
        end else begin
          if (exp_byte_q.size() == 0 || exp_nack_q.size() == 0) begin
            check("unexpected_byte", 1, 0);
          end else begin
            check("byte", cap, exp_byte_q.pop_front());
            check("ack_bit", sda_in, exp_nack_q.pop_front());
          end
          bitn = 0;
        end
      end
      if (prev_scl && !scl_in)
        ack_drive = (bitn == 8 && exp_nack_q.size() != 0) ? !exp_nack_q[0] : 1'b0;
      if (!prev_sclo && scl_out) begin
        out_active = 1'b1;
        out_len    = 0;
      end
      if (prev_sclo && !scl_out && out_active) begin
        if (out_len > max_hi) max_hi = out_len;
        out_active = 1'b0;
      end
      if (scl_out && out_active) out_len++;
      prev_scl  = scl_in;
      prev_sda  = sda_in;
      prev_sclo = scl_out;
    end
  end

  int s_start, s_stop, s_rise, s_acc, s_done;

  task automatic snap();
    s_start = start_cnt;
    s_stop  = stop_cnt;
    s_rise  = rise_cnt;
    s_acc   = acc_cnt;
    s_done  = done_cnt;
  endtask

  task automatic do_start(input logic push, input logic exp_err);
    @(negedge clk);
    start_req = 1'b1;
    @(posedge clk);
    #1 start_req = 1'b0;
    if (push) exp_err_q.push_back(exp_err);
    check("busy_after_start", busy, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input logic nack, input int stall);
    int t = 0;
    int scl_hi = 0;
    int rdy_lo = 0;
    @(negedge clk);
    while (!byte_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    repeat (stall) begin
      @(negedge clk);
      if (scl_out) scl_hi++;
      if (!byte_ready) rdy_lo++;
    end
    if (stall > 0) begin
      check("stall_scl_low", scl_hi, 0);
      check("stall_ready_held", rdy_lo, 0);
    end
    #1;
    tx_byte    = b;
    last_byte  = last;
    byte_valid = 1'b1;
    exp_byte_q.push_back(b);
    exp_nack_q.push_back(nack);
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic wait_done(input logic poke);
    int t = 0;
    @(negedge clk);
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      check("done_timeout", 0, 1);
      return;
    end
    if (poke) start_req = 1'b1;
    @(posedge clk);
    #1 start_req = 1'b0;
    if (poke) check("start_on_done_ignored", busy, 0);
  endtask

  task automatic stretch_bit(input int nbits_before);
    int base = rise_cnt;
    int t = 0;
    @(negedge clk);
    while (!(rise_cnt >= base + nbits_before && !scl_out) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    stretch = 1'b1;
    t = 0;
    while (!scl_out && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!scl_out) check("stretch_timeout", 0, 1);
    repeat (10) @(posedge clk);
    #1 stretch = 1'b0;
  endtask

  initial begin
    int base;
    int t;
    rst = 1'b1; start_req = 1'b0; byte_valid = 1'b0; last_byte = 1'b0; tx_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", scl_out, 1);
    check("rst_sda", sda_out, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_error", ack_error, 0);
    check("rst_byte_ready", byte_ready, 0);
    rst = 1'b0;

    // 1: single byte 0xA4, also start_req coincident with done
    snap(); max_hi = 0;
    do_start(1'b1, 1'b0);
    check("t1_sda_low_in_start", sda_out, 0);
    check("t1_scl_high_in_start", scl_out, 1);
    send_byte(8'hA4, 1'b1, 1'b0, 0);
    wait_done(1'b1);
    check("t1_starts", start_cnt - s_start, 1);
    check("t1_stops", stop_cnt - s_stop, 1);
    check("t1_scl_rises", rise_cnt - s_rise, 10);
    check("t1_accepts", acc_cnt - s_acc, 1);
    check("t1_dones", done_cnt - s_done, 1);
    check("t1_scl_high_len", max_hi, 2 * QTR_CNT);

    // 2: two bytes, start_req while busy must be ignored
    snap();
    do_start(1'b1, 1'b0);
    send_byte(8'h50, 1'b0, 1'b0, 0);
    @(negedge clk); start_req = 1'b1;
    @(posedge clk); #1 start_req = 1'b0;
    send_byte(8'h3C, 1'b1, 1'b0, 0);
    wait_done(1'b0);
    check("t2_starts", start_cnt - s_start, 1);
    check("t2_stops", stop_cnt - s_stop, 1);
    check("t2_scl_rises", rise_cnt - s_rise, 19);
    check("t2_accepts", acc_cnt - s_acc, 2);
    check("t2_dones", done_cnt - s_done, 1);

    // 3: NACK on address, second byte offered but never taken
    snap();
    do_start(1'b1, 1'b1);
    send_byte(8'h51, 1'b0, 1'b1, 0);
    tx_byte = 8'h77; last_byte = 1'b1; byte_valid = 1'b1;
    wait_done(1'b0);
    byte_valid = 1'b0;
    check("t3_scl_rises", rise_cnt - s_rise, 10);
    check("t3_accepts", acc_cnt - s_acc, 1);
    check("t3_stops", stop_cnt - s_stop, 1);
    check("t3_dones", done_cnt - s_done, 1);

    // 4: 40-cycle stall in LOAD before second byte
    snap();
    do_start(1'b1, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0, 0);
    send_byte(8'hC3, 1'b1, 1'b0, 40);
    wait_done(1'b0);
    check("t4_scl_rises", rise_cnt - s_rise, 19);
    check("t4_accepts", acc_cnt - s_acc, 2);

    // 5: slave stretches SCL for 10 cycles in Q2 of the fourth bit
    snap(); max_hi = 0;
    do_start(1'b1, 1'b0);
    fork
      send_byte(8'h96, 1'b1, 1'b0, 0);
      stretch_bit(3);
    join
    wait_done(1'b0);
    check("t5_scl_high_len", max_hi, 2 * QTR_CNT + 10);
    check("t5_scl_rises", rise_cnt - s_rise, 10);

    // 6: reset asserted during bit 3
    snap();
    do_start(1'b0, 1'b0);
    base = rise_cnt;
    send_byte(8'hE7, 1'b1, 1'b0, 0);
    t = 0;
    while (!(rise_cnt >= base + 4 && !scl_out) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_scl_released", scl_out, 1);
    check("t6_sda_released", sda_out, 1);
    check("t6_busy_cleared", busy, 0);
    check("t6_ready_cleared", byte_ready, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    exp_byte_q.delete(); exp_nack_q.delete(); exp_err_q.delete();
    repeat (20) @(negedge clk);
    check("t6_no_done", done_cnt - s_done, 0);
    check("t6_no_stop", stop_cnt - s_stop, 0);

    // 7: transaction after reset recovery
    snap();
    do_start(1'b1, 1'b0);
    send_byte(8'h3B, 1'b1, 1'b0, 0);
    wait_done(1'b0);
    check("t7_dones", done_cnt - s_done, 1);
    check("t7_accepts", acc_cnt - s_acc, 1);
    check("t7_queue_drained", exp_byte_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
